// File: rtl/ram_march_bist.sv
`default_nettype none
// ============================================================================
// Module : ram_march_bist
// March C- self-test initiator for a single-port synchronous RAM; reports
// pass/fail and captures the first mismatch.
// Rev    : 1.0
// ============================================================================
module ram_march_bist #(
  parameter int                ADDR_W = 3,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] BG     = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [2:0]        fail_elem_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_exp_o,
  output logic [DATA_W-1:0] fail_got_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i
);

  localparam logic [1:0]        S_IDLE     = 2'd0;
  localparam logic [1:0]        S_RUN      = 2'd1;
  localparam logic [1:0]        S_DONE     = 2'd2;
  localparam logic [2:0]        ELEM_DOWN0 = 3'd3;
  localparam logic [2:0]        ELEM_LAST  = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_phase_q, rd_phase_d;
  logic              pass_q, pass_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
  logic [DATA_W-1:0] fail_got_q, fail_got_d;

  logic [DATA_W-1:0] w_exp;
  logic [DATA_W-1:0] w_wdata;
  logic [2:0]        w_elem_nxt;
  logic              w_run;
  logic              w_down;
  logic              w_has_read;
  logic              w_has_write;
  logic              w_step;
  logic              w_last_addr;
  logic              w_mismatch;
  logic              w_test_end;

  // Expected read value and write value of each March element.
  always_comb begin
    w_exp   = BG;
    w_wdata = BG;
    case (elem_q)
      3'd0:    begin w_exp = BG;  w_wdata = BG;  end
      3'd1:    begin w_exp = BG;  w_wdata = ~BG; end
      3'd2:    begin w_exp = ~BG; w_wdata = BG;  end
      3'd3:    begin w_exp = BG;  w_wdata = ~BG; end
      3'd4:    begin w_exp = ~BG; w_wdata = BG;  end
      default: begin w_exp = BG;  w_wdata = BG;  end
    endcase
  end

  assign w_run       = (state_q == S_RUN);
  assign w_down      = (elem_q >= ELEM_DOWN0);
  assign w_has_read  = (elem_q != 3'd0);
  assign w_has_write = (elem_q != ELEM_LAST);
  assign w_elem_nxt  = elem_q + 3'd1;
  // An address finishes in its only cycle (write-only) or its compare cycle.
  assign w_step      = w_run && (!w_has_read || rd_phase_q);
  assign w_last_addr = w_down ? (addr_q == '0) : (addr_q == '1);
  assign w_mismatch  = w_run && w_has_read && rd_phase_q && (mem_dout_i != w_exp);
  assign w_test_end  = w_step && w_last_addr && (elem_q == ELEM_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (w_mismatch || w_test_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o     = w_run;
    done_o     = (state_q == S_DONE);
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_din_o  = '0;
    if (w_run) begin
      mem_addr_o = addr_q;
      mem_din_o  = w_wdata;
      mem_we_o   = !rst && w_has_write && w_step && !w_mismatch;
    end
  end

  always_comb begin
    elem_d      = elem_q;
    addr_d      = addr_q;
    rd_phase_d  = rd_phase_q;
    pass_d      = pass_q;
    fail_elem_d = fail_elem_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_got_d  = fail_got_q;
    if (state_q == S_IDLE && start_i) begin
      elem_d      = 3'd0;
      addr_d      = '0;
      rd_phase_d  = 1'b0;
      pass_d      = 1'b0;
      fail_elem_d = 3'd0;
      fail_addr_d = '0;
      fail_exp_d  = '0;
      fail_got_d  = '0;
    end else if (w_run) begin
      if (w_mismatch) begin
        fail_elem_d = elem_q;
        fail_addr_d = addr_q;
        fail_exp_d  = w_exp;
        fail_got_d  = mem_dout_i;
      end else if (w_has_read && !rd_phase_q) begin
        rd_phase_d = 1'b1;
      end else begin
        rd_phase_d = 1'b0;
        if (w_last_addr) begin
          elem_d = w_elem_nxt;
          addr_d = (w_elem_nxt >= ELEM_DOWN0) ? '1 : '0;
          if (elem_q == ELEM_LAST) pass_d = 1'b1;
        end else begin
          addr_d = w_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      elem_q      <= 3'd0;
      addr_q      <= '0;
      rd_phase_q  <= 1'b0;
      pass_q      <= 1'b0;
      fail_elem_q <= 3'd0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      rd_phase_q  <= rd_phase_d;
      pass_q      <= pass_d;
      fail_elem_q <= fail_elem_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_got_q  <= fail_got_d;
    end
  end

  assign pass_o      = pass_q;
  assign fail_elem_o = fail_elem_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_exp_o  = fail_exp_q;
  assign fail_got_o  = fail_got_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_march_bist.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_march_bist
// Bench for ram_march_bist: two instances (default and BG=8'hA5) beside RAM
// models, one with an injectable stuck-at-0 cell.
// Rev    : 1.0
// ============================================================================
module tb_ram_march_bist;

  typedef struct {
    logic       pass;
    logic [2:0] elem;
    logic [2:0] addr;
    logic [7:0] exp;
    logic [7:0] got;
    int         cycles;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, startb = 1'b0;
  logic       busy0, done0, pass0, we0, busyb, doneb, passb, web;
  logic [2:0] felem0, faddr0, addr0, felemb, faddrb, addrb;
  logic [7:0] fexp0, fgot0, din0, dout0, fexpb, fgotb, dinb, doutb;
  logic [7:0] mem0 [8];
  logic [7:0] memb [8];
  logic       fault_en = 1'b0;

  res_t q0[$];
  res_t qb[$];
  res_t r0, rb;
  int   cnt0 = 0, cntb = 0;
  int   n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  ram_march_bist dut0 (
    .clk(clk), .rst(rst), .start_i(start0), .busy_o(busy0), .done_o(done0),
    .pass_o(pass0), .fail_elem_o(felem0), .fail_addr_o(faddr0),
    .fail_exp_o(fexp0), .fail_got_o(fgot0), .mem_we_o(we0),
    .mem_addr_o(addr0), .mem_din_o(din0), .mem_dout_i(dout0)
  );

  ram_march_bist #(.ADDR_W(3), .DATA_W(8), .BG(8'hA5)) dutb (
    .clk(clk), .rst(rst), .start_i(startb), .busy_o(busyb), .done_o(doneb),
    .pass_o(passb), .fail_elem_o(felemb), .fail_addr_o(faddrb),
    .fail_exp_o(fexpb), .fail_got_o(fgotb), .mem_we_o(web),
    .mem_addr_o(addrb), .mem_din_o(dinb), .mem_dout_i(doutb)
  );

  // RAM models: 1-cycle registered read, dout holds during writes.
  always @(posedge clk) begin
    if (we0) mem0[addr0] <= din0;
    else dout0 <= (fault_en && addr0 == 3'd5) ? (mem0[addr0] & 8'hFE) : mem0[addr0];
    if (web) memb[addrb] <= dinb;
    else doutb <= memb[addrb];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic res_t mk(input logic p, input logic [2:0] e, input logic [2:0] a,
                              input logic [7:0] x, input logic [7:0] g, input int c);
    res_t r;
    r.pass = p; r.elem = e; r.addr = a; r.exp = x; r.got = g; r.cycles = c;
    return r;
  endfunction

  // Scoreboard: each done pulse pops the result expected when the test started.
  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) check("unexpected_done0", 1, 0);
      else begin
        r0 = q0.pop_front();
        check("pass0", pass0, r0.pass);
        check("fail_elem0", felem0, r0.elem);
        check("fail_addr0", faddr0, r0.addr);
        check("fail_exp0", fexp0, r0.exp);
        check("fail_got0", fgot0, r0.got);
        check("run_len0", cnt0, r0.cycles);
      end
    end
    cnt0 <= busy0 ? cnt0 + 1 : 0;
  end

  always @(negedge clk) begin
    if (doneb) begin
      if (qb.size() == 0) check("unexpected_doneb", 1, 0);
      else begin
        rb = qb.pop_front();
        check("passb", passb, rb.pass);
        check("fail_elemb", felemb, rb.elem);
        check("run_lenb", cntb, rb.cycles);
      end
    end
    cntb <= busyb ? cntb + 1 : 0;
  end

  task automatic drain(input bit which, input int limit);
    for (int i = 0; i < limit; i++) begin
      if ((which ? qb.size() : q0.size()) == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    check(which ? "drain_b" : "drain_0", which ? qb.size() : q0.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_we", we0, 0);
    check("rst_addr", addr0, 0);
    check("rst_fails", {felem0, faddr0, fexp0, fgot0}, 0);
    rst = 1'b0;

    // Fault-free run.
    @(negedge clk);
    q0.push_back(mk(1'b1, 3'd0, 3'd0, 8'h00, 8'h00, 88));
    start0 = 1'b1;
    for (int c = 1; c <= 88; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (c == 1) check("busy_rise", busy0, 1);
      if (c <= 8) begin
        check("m0_we", we0, 1);
        check("m0_addr", addr0, c - 1);
        check("m0_din", din0, 8'h00);
      end
      if (c == 41) begin
        check("m3_first_we", we0, 0);
        check("m3_first_addr", addr0, 7);
      end
    end
    drain(1'b0, 20);

    // Stuck-at-0 bit 0 at addr 5: abort on the M2 compare.
    fault_en = 1'b1;
    q0.push_back(mk(1'b0, 3'd2, 3'd5, 8'hFF, 8'hFE, 36));
    start0 = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (c == 36) begin
        check("abort_we", we0, 0);
        check("abort_addr", addr0, 5);
      end
    end
    drain(1'b0, 20);
    repeat (3) @(negedge clk);
    check("fail_held", {pass0, felem0}, {1'b0, 3'd2});
    fault_en = 1'b0;

    // Reset during RUN cycle 30 aborts silently.
    start0 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    rst = 1'b1;
    #1 check("rst_cycle_we", we0, 0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy0, 0);
    check("abort_outs", {done0, pass0, we0, addr0, din0, felem0, faddr0, fexp0, fgot0}, 0);
    repeat (5) @(negedge clk);
    q0.push_back(mk(1'b1, 3'd0, 3'd0, 8'h00, 8'h00, 88));
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    drain(1'b0, 120);

    // start pulses inside RUN are ignored.
    q0.push_back(mk(1'b1, 3'd0, 3'd0, 8'h00, 8'h00, 88));
    start0 = 1'b1;
    for (int c = 1; c <= 88; c++) begin
      @(negedge clk);
      start0 = (c == 10 || c == 50);
    end
    start0 = 1'b0;
    drain(1'b0, 20);
    repeat (5) @(negedge clk);
    check("no_restart", busy0, 0);

    // start held high: DONE, one IDLE cycle, then a fresh RUN.
    q0.push_back(mk(1'b1, 3'd0, 3'd0, 8'h00, 8'h00, 88));
    q0.push_back(mk(1'b1, 3'd0, 3'd0, 8'h00, 8'h00, 88));
    start0 = 1'b1;
    repeat (89) @(negedge clk);
    check("held_done", done0, 1);
    @(negedge clk);
    check("held_gap", {busy0, pass0}, {1'b0, 1'b1});
    @(negedge clk);
    start0 = 1'b0;
    check("held_rerun", busy0, 1);
    check("held_pass_clr", pass0, 0);
    drain(1'b0, 200);

    // BG = 8'hA5 instance.
    qb.push_back(mk(1'b1, 3'd0, 3'd0, 8'h00, 8'h00, 88));
    startb = 1'b1;
    for (int c = 1; c <= 88; c++) begin
      @(negedge clk);
      startb = 1'b0;
      if (c == 1) check("bg_m0", {web, dinb}, {1'b1, 8'hA5});
      if (c == 10) check("bg_m1", {web, addrb, dinb}, {1'b1, 3'd0, 8'h5A});
    end
    drain(1'b1, 20);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
- Built-in self-test initiator for the single-port synchronous RAM (clk, we, addr, din, dout; 1-cycle registered read; dout holds while we=1).
- Drives the RAM's write/address/data inputs and checks its read data with a March C- sequence.
- Reports pass/fail plus first-failure diagnostics.
- Sits beside the RAM; a mux (outside this block) selects between the BIST and functional masters.

Parameters:
- ADDR_W, 3, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- BG, {DATA_W{1'b0}}, data background. "0" = BG, "1" = ~BG.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin test. Sampled only in IDLE.
- busy  output  1  high while the test sequence runs.
- done  output  1  one-cycle pulse at test end (pass or abort).
- pass  output  1  result of the last completed test. Valid from done onward; held until next start.
- fail_elem  output  3  March element index (0-5) of the first mismatch.
- fail_addr  output  ADDR_W  address of the first mismatch.
- fail_exp  output  DATA_W  expected data at the first mismatch.
- fail_got  output  DATA_W  mem_dout value at the first mismatch.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_W  RAM address.
- mem_din  output  DATA_W  RAM write data.
- mem_dout  input  DATA_W  RAM read data. Valid the cycle after a we=0 access.

Behaviour:
- Reset: all outputs 0 (pass=0, mem_we=0). FSM goes to IDLE. rst overrides start and any in-flight operation. No RAM write occurs in a cycle where rst is high. Reset mid-test aborts with no done pulse.
- FSM states: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 moves to RUN on the next edge and clears pass and the fail_* fields to 0.
  - busy rises in the first RUN cycle.
  - start is ignored outside IDLE.
- March elements (⇑ = address 0..DEPTH-1, ⇓ = DEPTH-1..0):
  - M0 ⇑ w0
  - M1 ⇑ r0,w1
  - M2 ⇑ r1,w0
  - M3 ⇓ r0,w1
  - M4 ⇓ r1,w0
  - M5 ⇓ r0
- Per-address timing:
  - Write-only (M0): 1 cycle, mem_we=1.
  - Read+write (M1-M4):
    - Cycle A: mem_we=0, mem_addr=a (read issue).
    - Cycle B: compare mem_dout to the expected value. In the same cycle drive mem_we=1, mem_addr=a, mem_din=new value.
  - Read-only (M5):
    - Cycle A: read issue.
    - Cycle B: compare. mem_we=0 and mem_addr held at a.
- Total RUN length for a passing test: 11*DEPTH cycles (88 at default). There are no idle cycles between elements. The address counter wraps within each element and then reloads 0 (⇑) or DEPTH-1 (⇓).
- Mismatch:
  - On the first compare where mem_dout != expected, capture fail_elem, fail_addr, fail_exp and fail_got in that cycle.
  - Suppress the paired write (mem_we=0), then go to DONE next edge.
  - Later mismatches are never captured.
- DONE (1 cycle):
  - busy=0, done=1, mem_we=0.
  - pass=1 iff no mismatch occurred.
  - Next edge returns to IDLE.
  - If start is held high, a new test begins after one IDLE cycle.
- Outside RUN: mem_we=0, mem_addr=0, mem_din=0.
- Results (pass, fail_*) hold until the next accepted start or rst.

Test Plan:
- Fault-free RAM, default params, start pulse:
  - busy high exactly 88 cycles.
  - Cycles 1-8: mem_we=1, addr 0..7, din 8'h00.
  - First M3 read at addr 7.
  - done pulse with pass=1; fail_* = 0.
- RAM model with addr 5 bit0 stuck-at-0:
  - Abort in M2 read at addr 5.
  - fail_elem=2, fail_addr=5, fail_exp=8'hFF, fail_got=8'hFE, pass=0.
  - No write to addr 5 in the abort cycle.
- rst asserted on RUN cycle 30:
  - Next cycle busy=0, mem_we=0, all outputs 0.
  - No done pulse.
  - A subsequent start runs a full 88-cycle pass.
- start pulsed at RUN cycles 10 and 50: ignored; single test of 88 cycles.
- start held high: DONE, then one IDLE cycle, then RUN again; pass cleared to 0 at the new start.
- BG=8'hA5 with fault-free RAM: M0 writes 8'hA5, M1 writes 8'h5A; pass=1.
